conv_mac_filter: RTL and testbench
==================================

# conv_mac_filter

Parametrised K×K convolution filter core: the successor to the fixed 3×3 single-shot filter. It accumulates CH input-channel windows over a valid/ready stream and applies bias, fixed-point rescale, saturation and optional leaky-ReLU. It emits one output pixel per CH accepted beats. It sits between the line-buffer/window generator and the output feature-map writer in each convolution layer.

## Interface
Parameters:
- K, 3: kernel edge; K*K taps per beat
- DW, 10: signed width of pixels, weights, bias and output
- CH, 4: input channels accumulated per output pixel (≥1)
- FRAC, 9: fractional bits of the weight format; right-shift applied to the accumulated sum

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  beat valid
- in_ready  out  1  core can accept a beat
- x  in  K*K*DW  signed window pixels, tap (r,c) at bits [(r*K+c)*DW +: DW]
- w  in  K*K*DW  signed weights, same packing
- b  in  DW  signed bias, sampled with the last beat of a group
- relu  in  1  1 = leaky-ReLU on, sampled with the first beat of a group
- relu_c  in  8  unsigned negative slope, Q0.8, sampled with relu
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  DW  signed result
- out_sat  out  1  result was saturated; meaningful while out_valid

## Operation
- Beat accepted when in_valid && in_ready. Channel counter 0..CH-1 increments per accepted beat and wraps to 0 after CH-1 (last beat).
- Stage P: K*K signed products x*w (2*DW bits each) summed and registered as one partial sum.
- Stage A: ACCW = 2*DW + ceil(log2(K*K*CH)) + 1 bit signed accumulator. The first beat of a group loads the accumulator, and later beats add to it. No intermediate overflow is possible at this width.
- Finish: y = (acc + (b <<< FRAC)) >>> FRAC (arithmetic, floor). If y > 2^(DW-1)-1, output 2^(DW-1)-1 with out_sat=1. If y < -2^(DW-1), output -2^(DW-1) with out_sat=1.
- Activation on the saturated value s: relu=0 gives s. relu=1 and s ≥ 0 gives s. relu=1 and s < 0 gives (s*relu_c) >>> 8 (floor). The activation never re-saturates.
- States:
  - ACC: in_ready=1.
  - DRAIN: entered on acceptance of the last beat; in_ready=0; waits for stages P and A to complete.
  - HOLD: out_valid=1; in_ready=0; leaves to ACC on out_ready.
- One output group in flight. No overlap between groups.

## Timing
- Reset values: in_ready=0 during reset and 1 on the first cycle after release. out_valid=0, out_data=0, out_sat=0, counter=0, acc=0, state ACC.
- Latency: last beat accepted at edge t, partial sum registered at t, accumulator updated at t+1, out_valid/out_data/out_sat registered at t+2.
- Full-rate input inside a group: CH beats in CH consecutive cycles. Group period is CH+3 cycles when out_ready is held at 1.
- out_data/out_sat stay stable while out_valid && !out_ready. out_valid drops at the edge where out_ready is sampled high. in_ready rises on the same edge.
- in_valid while in_ready=0 is ignored; upstream must hold the beat.
- CH=1: every beat is both first and last.
- Reset asserted mid-group or in HOLD discards the partial group and any pending output. out_valid falls asynchronously.

## Test plan
All scenarios use K=3, DW=10, CH=4, FRAC=9.
- Basic: all x=64, w=64, b=0, relu=0, 4 back-to-back beats → out_data=288, out_sat=0, out_valid exactly 2 cycles after the 4th accept.
- Leaky: w=-64, x=64, b=0. relu=0 → -288. relu=1, relu_c=64 → -72. relu=1, relu_c=0 → 0.
- Bias/saturation: w=64, x=64, b=-300 → -12. x=w=511 → 511 with out_sat=1. x=511, w=-511 → -512 with out_sat=1.
- Backpressure: out_ready=0 for 5 cycles → out_data held, in_ready=0, extra in_valid beats not counted. Then out_ready=1 → one handshake and in_ready=1 the next cycle.
- Reset mid-group: 2 beats of x=w=511, pulse reset, then 4 beats of x=w=64 → 288. No stale contribution and no spurious out_valid.
- Throughput: 3 consecutive groups with out_ready=1 → outputs at a period of 7 cycles, counter wrap correct, relu/relu_c sampled per group.

Source files
------------

// File: rtl/conv_mac_filter.sv
// K x K multi-channel convolution MAC: accumulates CH window beats per output pixel,
// then applies bias, fixed-point rescale, saturation and optional leaky-ReLU.
module conv_mac_filter #(
    parameter int K    = 3,
    parameter int DW   = 10,
    parameter int CH   = 4,
    parameter int FRAC = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [K*K*DW-1:0]    x,
    input  logic [K*K*DW-1:0]    w,
    input  logic signed [DW-1:0] b,
    input  logic                 relu,
    input  logic [7:0]           relu_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_sat
);
    localparam int TAPS = K * K;
    localparam int ACCW = 2 * DW + $clog2(TAPS * CH) + 1;
    localparam int SW   = ACCW + 1;
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam logic signed [SW-1:0] YMAX = SW'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] YMIN = -YMAX - SW'(1);

    typedef enum logic [1:0] {S_ACC, S_DRAIN, S_HOLD} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   accept, first_beat, last_beat;
    logic signed [2*DW-1:0] prod [TAPS];
    logic signed [ACCW-1:0] psum;
    logic signed [ACCW-1:0] psum_p0, acc_p1;
    logic                   vld_p0, first_p0, last_p0, vld_p1;
    logic signed [DW-1:0]   bias_p0;
    logic                   relu_g;
    logic [7:0]             relu_c_g;
    logic [DW:0]            sat_res;
    logic signed [DW-1:0]   act;

    // Returns {saturated, value} of floor((a + bias*2^FRAC) / 2^FRAC) clamped to DW bits.
    function automatic logic [DW:0] rescale_sat(input logic signed [ACCW-1:0] a,
                                                input logic signed [DW-1:0] bias);
        logic signed [SW-1:0] y;
        y = (SW'(a) + (SW'(bias) <<< FRAC)) >>> FRAC;
        if (y > YMAX)
            return {1'b1, YMAX[DW-1:0]};
        else if (y < YMIN)
            return {1'b1, YMIN[DW-1:0]};
        return {1'b0, y[DW-1:0]};
    endfunction

    // Negative slope is Q0.8 and below one, so the scaled value always fits in DW bits.
    function automatic logic signed [DW-1:0] leaky(input logic signed [DW-1:0] s,
                                                   input logic en,
                                                   input logic [7:0] c);
        logic signed [DW+8:0] p;
        p = (s * $signed({1'b0, c})) >>> 8;
        if (en && s < 0)
            return p[DW-1:0];
        return s;
    endfunction

    assign in_ready   = (state == S_ACC) && !reset;
    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == CW'(CH - 1));

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        assign prod[i] = $signed(x[i*DW +: DW]) * $signed(w[i*DW +: DW]);
    end

    always_comb begin
        psum = '0;
        for (int i = 0; i < TAPS; i++)
            psum = psum + ACCW'(prod[i]);
    end

    assign sat_res = rescale_sat(acc_p1, bias_p0);
    assign act     = leaky(sat_res[DW-1:0], relu_g, relu_c_g);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psum_p0  <= '0;
            vld_p0   <= 1'b0;
            first_p0 <= 1'b0;
            last_p0  <= 1'b0;
            bias_p0  <= '0;
            relu_g   <= 1'b0;
            relu_c_g <= '0;
            acc_p1   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            // Stage P: product sum of the accepted beat
            vld_p0 <= accept;
            if (accept) begin
                psum_p0  <= psum;
                first_p0 <= first_beat;
                last_p0  <= last_beat;
                if (first_beat) begin
                    relu_g   <= relu;
                    relu_c_g <= relu_c;
                end
                if (last_beat)
                    bias_p0 <= b;
            end
            // Stage A: channel accumulation
            vld_p1 <= vld_p0 && last_p0;
            if (vld_p0)
                acc_p1 <= first_p0 ? psum_p0 : acc_p1 + psum_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_ACC;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (accept) begin
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                        if (last_beat)
                            state <= S_DRAIN;
                    end
                end
                // Finish: rescale, saturate and activate into the output register
                S_DRAIN: begin
                    if (vld_p1) begin
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                        out_data  <= act;
                        out_sat   <= sat_res[DW];
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state     <= S_ACC;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_filter.sv
// Directed bench for conv_mac_filter (K=3, DW=10, CH=4, FRAC=9) with hand-computed results.
module tb_conv_mac_filter;
    localparam int K    = 3;
    localparam int DW   = 10;
    localparam int CH   = 4;
    localparam int FRAC = 9;
    localparam int TAPS = K * K;

    logic                 clk = 1'b0;
    logic                 reset, in_valid, in_ready, relu, out_valid, out_ready, out_sat;
    logic [K*K*DW-1:0]    x, w;
    logic signed [DW-1:0] b, out_data;
    logic [7:0]           relu_c;
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int t1, t2, t3;

    conv_mac_filter #(.K(K), .DW(DW), .CH(CH), .FRAC(FRAC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .b(b), .relu(relu), .relu_c(relu_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Drives n beats at full rate; relu/relu_c are valid only on the first beat and
    // b only on the last beat, the other beats carry decoys.
    task automatic feed(input logic signed [DW-1:0] xv, input logic signed [DW-1:0] wv,
                        input logic signed [DW-1:0] bv, input logic rl,
                        input logic [7:0] rc, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < TAPS; t++) begin
                x[t*DW +: DW] = xv;
                w[t*DW +: DW] = wv;
            end
            relu   = (i == 0) ? rl : ~rl;
            relu_c = (i == 0) ? rc : ~rc;
            b      = (i == CH - 1) ? bv : 10'sd123;
            guard  = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20)
                chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int at);
        int g;
        g = 0;
        while (!out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        at = cyc;
    endtask

    task automatic expect_out(input string tag, input int d, input logic s);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_sat"}, {31'd0, out_sat}, {31'd0, s});
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        relu = 1'b0; relu_c = '0; b = '0; x = '0; w = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // basic group with exact latency
        feed(64, 64, 0, 1'b0, 8'd0, CH);
        chk("lat0_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat2_valid", {31'd0, out_valid}, 32'd1);
        expect_out("basic", 288, 1'b0);
        @(negedge clk);
        chk("basic_done_valid", {31'd0, out_valid}, 32'd0);
        chk("basic_done_ready", {31'd0, in_ready}, 32'd1);

        // leaky-ReLU
        feed(64, -64, 0, 1'b0, 8'd0, CH);
        wait_out("neg", t1);
        expect_out("neg", -288, 1'b0);
        feed(64, -64, 0, 1'b1, 8'd64, CH);
        wait_out("leaky64", t1);
        expect_out("leaky64", -72, 1'b0);
        feed(64, -64, 0, 1'b1, 8'd0, CH);
        wait_out("leaky0", t1);
        expect_out("leaky0", 0, 1'b0);

        // bias and saturation
        feed(64, 64, -300, 1'b0, 8'd0, CH);
        wait_out("bias", t1);
        expect_out("bias", -12, 1'b0);
        feed(511, 511, 0, 1'b0, 8'd0, CH);
        wait_out("satpos", t1);
        expect_out("satpos", 511, 1'b1);
        feed(511, -511, 0, 1'b0, 8'd0, CH);
        wait_out("satneg", t1);
        expect_out("satneg", -512, 1'b1);
        feed(511, -511, 0, 1'b1, 8'd128, CH);
        wait_out("satleaky", t1);
        expect_out("satleaky", -256, 1'b1);

        // backpressure with ignored extra beats
        @(negedge clk);
        out_ready = 1'b0;
        feed(64, 64, 0, 1'b0, 8'd0, CH);
        wait_out("bp", t1);
        for (int i = 0; i < TAPS; i++) begin
            x[i*DW +: DW] = 10'sd511;
            w[i*DW +: DW] = 10'sd511;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_data", out_data, 288);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        feed(64, 64, 0, 1'b0, 8'd0, CH);
        wait_out("bp_next", t1);
        expect_out("bp_next", 288, 1'b0);

        // asynchronous reset while holding an output
        @(negedge clk);
        out_ready = 1'b0;
        feed(64, 64, 0, 1'b0, 8'd0, CH);
        wait_out("arst", t1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;

        // reset in the middle of a group
        @(negedge clk);
        feed(511, 511, 0, 1'b0, 8'd0, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        feed(64, 64, 0, 1'b0, 8'd0, CH);
        wait_out("midrst", t1);
        expect_out("midrst", 288, 1'b0);

        // three back-to-back groups at full throughput
        feed(64, -64, 0, 1'b1, 8'd64, CH);
        wait_out("tp1", t1);
        expect_out("tp1", -72, 1'b0);
        feed(64, -64, 0, 1'b0, 8'd0, CH);
        wait_out("tp2", t2);
        expect_out("tp2", -288, 1'b0);
        feed(64, -64, 0, 1'b1, 8'd0, CH);
        wait_out("tp3", t3);
        expect_out("tp3", 0, 1'b0);
        chk("tp_period12", t2 - t1, 7);
        chk("tp_period23", t3 - t2, 7);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
